osd_overlay: RTL and testbench

On-screen-display overlay stage between `video_mixer` output and the HDMI/VGA scaler input. It takes 8-bit RGB, HS, VS and DE after scanline processing and measures the active picture size each frame. It centres a 1-bpp OSD bitmap held in internal RAM on the picture: set pixels are drawn white and the background under the window is dimmed 50%. Sync and DE pass through with the same fixed delay as the colour.

---
 rtl/osd_overlay_if.sv | 36 +++
 rtl/osd_overlay.sv | 149 ++++++++++++++
 tb/tb_osd_overlay.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/osd_overlay_if.sv
`default_nettype none
// =============================================================================
// Module   : osd_overlay_if
// Brief    : Video stream, bitmap write port and status of the OSD overlay stage.
// Revision : 1.0 - initial release
// =============================================================================
interface osd_overlay_if #(
  parameter int OSD_W = 256,
  parameter int OSD_H = 64
) ();
  localparam int ADDR_W = $clog2(OSD_W * OSD_H / 8);

  logic              ce_pix;
  logic              osd_enable;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        R_in, G_in, B_in;
  logic              HS_in, VS_in, DE_in;
  logic [7:0]        R_out, G_out, B_out;
  logic              HS_out, VS_out, DE_out;
  logic              osd_active;

  modport master (
    output ce_pix, osd_enable, wr_en, wr_addr, wr_data,
    output R_in, G_in, B_in, HS_in, VS_in, DE_in,
    input  R_out, G_out, B_out, HS_out, VS_out, DE_out, osd_active
  );

  modport slave (
    input  ce_pix, osd_enable, wr_en, wr_addr, wr_data,
    input  R_in, G_in, B_in, HS_in, VS_in, DE_in,
    output R_out, G_out, B_out, HS_out, VS_out, DE_out, osd_active
  );
endinterface
`default_nettype wire

// File: rtl/osd_overlay.sv
`default_nettype none
// =============================================================================
// Module   : osd_overlay
// Brief    : Centres a 1-bpp OSD bitmap on the measured active picture, drawing
//            set pixels white and dimming the window background; 2-clock latency.
// Revision : 1.0 - initial release
// =============================================================================
module osd_overlay #(
  parameter int OSD_W = 256,
  parameter int OSD_H = 64
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  osd_overlay_if.slave bus
);
  localparam int                ADDR_W      = $clog2(OSD_W * OSD_H / 8);
  localparam int                DEPTH       = OSD_W * OSD_H / 8;
  localparam logic [11:0]       C_OSD_W     = 12'(OSD_W);
  localparam logic [11:0]       C_OSD_H     = 12'(OSD_H);
  localparam logic [ADDR_W-1:0] C_ROW_BYTES = ADDR_W'(OSD_W / 8);
  localparam logic [10:0]       C_CNT_MAX   = 11'h7FF;

  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        r_rd_data;
  logic              r_de_d, r_vs_d;
  logic [10:0]       r_hcnt, r_vcnt, r_h_meas, r_h_active, r_v_active;
  logic              r_osd_active;
  logic [7:0]        r_r1, r_g1, r_b1;
  logic              r_hs1, r_vs1, r_de1, r_win1;
  logic [2:0]        r_bit1;
  logic [7:0]        r_r_out, r_g_out, r_b_out;
  logic              r_hs_out, r_vs_out, r_de_out;

  logic              w_de_fall, w_vs_rise;
  logic [10:0]       w_h_meas_line, w_vcnt_line;
  logic [10:0]       w_h_start, w_v_start, w_hoff, w_voff;
  logic [11:0]       w_h_end, w_v_end;
  logic              w_in_h, w_in_v, w_win, w_pix;
  logic [ADDR_W-1:0] w_rd_addr;

  // A line end coinciding with frame start is folded in before the frame latches.
  assign w_de_fall     = r_de_d & ~bus.DE_in;
  assign w_vs_rise     = bus.VS_in & ~r_vs_d;
  assign w_h_meas_line = w_de_fall ? r_hcnt : r_h_meas;
  assign w_vcnt_line   = !w_de_fall ? r_vcnt :
                         (r_vcnt == C_CNT_MAX) ? r_vcnt : r_vcnt + 11'd1;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_de_d       <= 1'b0;
      r_vs_d       <= 1'b0;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_h_meas     <= '0;
      r_h_active   <= '0;
      r_v_active   <= '0;
      r_osd_active <= 1'b0;
    end else begin
      r_de_d   <= bus.DE_in;
      r_vs_d   <= bus.VS_in;
      r_h_meas <= w_h_meas_line;
      if (!bus.DE_in) begin
        r_hcnt <= '0;
      end else if (bus.ce_pix && r_hcnt != C_CNT_MAX) begin
        r_hcnt <= r_hcnt + 11'd1;
      end
      if (w_vs_rise) begin
        r_h_active   <= w_h_meas_line;
        r_v_active   <= w_vcnt_line;
        r_vcnt       <= '0;
        r_osd_active <= bus.osd_enable;
      end else begin
        r_vcnt <= w_vcnt_line;
      end
    end
  end

  // Origin follows the frame-constant active size, so it is stable all frame.
  assign w_h_start = ({1'b0, r_h_active} >= C_OSD_W) ?
                     11'(({1'b0, r_h_active} - C_OSD_W) >> 1) : '0;
  assign w_v_start = ({1'b0, r_v_active} >= C_OSD_H) ?
                     11'(({1'b0, r_v_active} - C_OSD_H) >> 1) : '0;
  assign w_h_end   = {1'b0, w_h_start} + C_OSD_W;
  assign w_v_end   = {1'b0, w_v_start} + C_OSD_H;
  assign w_in_h    = (r_hcnt >= w_h_start) && ({1'b0, r_hcnt} < w_h_end);
  assign w_in_v    = (r_vcnt >= w_v_start) && ({1'b0, r_vcnt} < w_v_end);
  assign w_win     = r_osd_active & bus.DE_in & w_in_h & w_in_v;
  assign w_hoff    = r_hcnt - w_h_start;
  assign w_voff    = r_vcnt - w_v_start;
  assign w_rd_addr = ADDR_W'(w_voff) * C_ROW_BYTES + ADDR_W'(w_hoff >> 3);

  always_ff @(posedge clk_sys) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  function automatic logic [7:0] f_blend(input logic [7:0] c, input logic win,
                                         input logic pix);
    if (!win) return c;
    return pix ? 8'hFF : {1'b0, c[7:1]};
  endfunction

  assign w_pix = r_rd_data[r_bit1];

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_r1     <= '0;
      r_g1     <= '0;
      r_b1     <= '0;
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
      r_de1    <= 1'b0;
      r_win1   <= 1'b0;
      r_bit1   <= '0;
      r_r_out  <= '0;
      r_g_out  <= '0;
      r_b_out  <= '0;
      r_hs_out <= 1'b0;
      r_vs_out <= 1'b0;
      r_de_out <= 1'b0;
    end else begin
      r_r1     <= bus.R_in;
      r_g1     <= bus.G_in;
      r_b1     <= bus.B_in;
      r_hs1    <= bus.HS_in;
      r_vs1    <= bus.VS_in;
      r_de1    <= bus.DE_in;
      r_win1   <= w_win;
      r_bit1   <= ~w_hoff[2:0];
      r_r_out  <= f_blend(r_r1, r_win1, w_pix);
      r_g_out  <= f_blend(r_g1, r_win1, w_pix);
      r_b_out  <= f_blend(r_b1, r_win1, w_pix);
      r_hs_out <= r_hs1;
      r_vs_out <= r_vs1;
      r_de_out <= r_de1;
    end
  end

  assign bus.R_out      = r_r_out;
  assign bus.G_out      = r_g_out;
  assign bus.B_out      = r_b_out;
  assign bus.HS_out     = r_hs_out;
  assign bus.VS_out     = r_vs_out;
  assign bus.DE_out     = r_de_out;
  assign bus.osd_active = r_osd_active;
endmodule
`default_nettype wire

// File: tb/tb_osd_overlay.sv
`default_nettype none
// =============================================================================
// Module   : tb_osd_overlay
// Brief    : Random-pixel frames against a frame-level overlay reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_osd_overlay;
  localparam int OSD_W     = 32;
  localparam int OSD_H     = 8;
  localparam int ROW_BYTES = OSD_W / 8;
  localparam int N_BYTES   = OSD_W * OSD_H / 8;
  localparam int ADDR_W    = $clog2(N_BYTES);

  logic clk_sys = 1'b0;
  logic rst_n;
  always #5 clk_sys = ~clk_sys;

  osd_overlay_if #(.OSD_W(OSD_W), .OSD_H(OSD_H)) bus ();
  osd_overlay #(.OSD_W(OSD_W), .OSD_H(OSD_H)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [26:0] q_v [$];
  string       q_t [$];

  // reference model: bitmap as pixels, frame geometry from whole lines/frames
  bit   bmp [OSD_W*OSD_H];
  logic m_on, m_de_prev, m_vs_prev;
  int   m_hs, m_vs, m_lines, m_lastw, m_curw;

  logic              en_drv, rst_req, wq_en, tog_val;
  logic [ADDR_W-1:0] wq_addr;
  logic [7:0]        wq_data, wr_byte;
  int                tog_line, rst_line, rst_px, wr_line, wr_px, wr_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (q_v.size() >= 2)
      check(q_t.pop_front(),
            {5'd0, bus.R_out, bus.G_out, bus.B_out, bus.HS_out, bus.VS_out, bus.DE_out},
            {5'd0, q_v.pop_front()});
    check("osd_active", {31'd0, bus.osd_active}, {31'd0, m_on});
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs, input logic ce,
                       input int x, input int y);
    logic [7:0] r, g, b, pr, pg, pb;
    logic       win, pbit;
    string      tag;
    int         a;
    r = 8'($urandom);
    g = 8'($urandom);
    b = 8'($urandom);
    rst_n = ~rst_req;
    bus.ce_pix = ce;      bus.osd_enable = en_drv;
    bus.wr_en = wq_en;    bus.wr_addr = wq_addr;  bus.wr_data = wq_data;
    bus.R_in = r;         bus.G_in = g;           bus.B_in = b;
    bus.HS_in = hs;       bus.VS_in = vs;         bus.DE_in = de;
    if (rst_req) begin
      q_v.delete(); q_t.delete();
      q_v.push_back('0); q_t.push_back("rst");
      q_v.push_back('0); q_t.push_back("rst");
      m_on = 1'b0; m_hs = 0; m_vs = 0; m_lines = 0; m_lastw = 0; m_curw = 0;
      m_de_prev = 1'b0; m_vs_prev = 1'b0;
    end else begin
      win  = m_on && de && x >= m_hs && x < m_hs + OSD_W && y >= m_vs && y < m_vs + OSD_H;
      pbit = win ? bmp[(y - m_vs) * OSD_W + (x - m_hs)] : 1'b0;
      if (!win)     {pr, pg, pb} = {r, g, b};
      else if (pbit) {pr, pg, pb} = 24'hFFFFFF;
      else          {pr, pg, pb} = {r >> 1, g >> 1, b >> 1};
      if (win) tag = "win";
      else if (m_on && de && (x == m_hs - 1 || x == m_hs + OSD_W ||
                              y == m_vs - 1 || y == m_vs + OSD_H)) tag = "border";
      else tag = "pass";
      q_v.push_back({pr, pg, pb, hs, vs, de});
      q_t.push_back(tag);
      if (m_de_prev && !de) begin
        m_lines++; m_lastw = m_curw; m_curw = 0;
      end
      if (de && ce) m_curw++;
      if (vs && !m_vs_prev) begin
        m_hs = (m_lastw >= OSD_W) ? (m_lastw - OSD_W) / 2 : 0;
        m_vs = (m_lines >= OSD_H) ? (m_lines - OSD_H) / 2 : 0;
        m_on = en_drv;
        m_lines = 0;
      end
      m_de_prev = de;
      m_vs_prev = vs;
      // bitmap changes after this cycle's read, matching read-old-data
      if (wq_en) begin
        a = int'(wq_addr);
        for (int k = 0; k < 8; k++)
          bmp[(a / ROW_BYTES) * OSD_W + (a % ROW_BYTES) * 8 + k] = wq_data[7-k];
      end
    end
    tick();
    rst_req = 1'b0;
    wq_en   = 1'b0;
  endtask

  task automatic clear_hooks();
    tog_line = -1; rst_line = -1; rst_px = -1; wr_line = -1; wr_px = -1;
  endtask

  task automatic load_bitmap(input logic rnd);
    for (int a = 0; a < N_BYTES; a++) begin
      wq_en   = 1'b1;
      wq_addr = ADDR_W'(a);
      wq_data = rnd ? 8'($urandom) : 8'hAA;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    end
  endtask

  // VS 2 clocks, back porch, lines of (4 blank + W*rate active), optional front porch
  task automatic frame(input int w, input int h, input int rate, input logic tight_end);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int y = 0; y < h; y++) begin
      for (int i = 0; i < 4; i++) drive(1'b0, i < 2, 1'b0, 1'b1, 0, y);
      for (int x = 0; x < w; x++) begin
        for (int c = 0; c < rate; c++) begin
          if (c == 0 && x == 0 && y == tog_line) en_drv = tog_val;
          if (c == 0 && x == rst_px && y == rst_line) rst_req = 1'b1;
          if (c == 0 && x == wr_px && y == wr_line) begin
            wq_en = 1'b1; wq_addr = ADDR_W'(wr_a); wq_data = wr_byte;
          end
          drive(1'b1, 1'b0, 1'b0, c == rate - 1, x, y);
        end
      end
    end
    if (!tight_end) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, h);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en_drv = 1'b0; rst_req = 1'b0; wq_en = 1'b0; wq_addr = '0; wq_data = '0;
    tog_val = 1'b0; wr_byte = '0; wr_a = 0;
    m_on = 1'b0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
    m_hs = 0; m_vs = 0; m_lines = 0; m_lastw = 0; m_curw = 0;
    clear_hooks();
    for (int i = 0; i < 3; i++) begin
      rst_req = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    end
    load_bitmap(1'b0);
    frame(96, 24, 1, 1'b0);                       // pass-through
    en_drv = 1'b1;
    frame(96, 24, 1, 1'b0);                       // centred, 0xAA pattern
    load_bitmap(1'b1);
    tog_line = 12; tog_val = 1'b0;
    frame(96, 24, 2, 1'b1);                       // half-rate ce, disable mid-frame, VS on DE fall
    clear_hooks();
    tog_line = 5; tog_val = 1'b1;
    frame(96, 24, 1, 1'b0);                       // off, re-enable mid-frame
    clear_hooks();
    wr_line = 8; wr_px = 32; wr_a = 0; wr_byte = 8'h80;
    frame(96, 24, 1, 1'b0);                       // same-cycle write to the byte being read
    clear_hooks();
    frame(24, 5, 1, 1'b0);                        // small picture, old origin
    frame(24, 5, 1, 1'b0);                        // origin 0, clipped window
    rst_line = 3; rst_px = 10;
    frame(96, 24, 1, 1'b0);                       // reset mid-window
    clear_hooks();
    frame(96, 24, 1, 1'b0);
    frame(96, 24, 1, 1'b0);
    frame(96, 0, 1, 1'b0);                        // frame without DE
    frame(96, 24, 1, 1'b0);
    frame(96, 24, 1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
